fanout_dispatcher: RTL and testbench

Single-clock stream dispatcher that takes one input stream and distributes it across the ten child instances a hierarchy node instantiates. Each item goes to exactly one child in strict round-robin order, or to all children in broadcast mode. It sits directly upstream of a node's child-instance row and is the stage that feeds it. It holds one item in an internal buffer and keeps a dispatch counter for debug.

---
 rtl/fanout_dispatcher.sv | 76 +++++++
 tb/tb_fanout_dispatcher.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_dispatcher.sv
// Single-clock stream dispatcher: one-entry buffer fanning items out to N_CHILD
// children, either to one child in strict round-robin order or to all of them (broadcast).
module fanout_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int N_CHILD = 10,
  parameter int CNT_W   = 16,
  localparam int PTR_W  = $clog2(N_CHILD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_bcast,
  output logic [N_CHILD-1:0] out_valid,
  input  logic [N_CHILD-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [PTR_W-1:0]   rr_ptr,
  output logic [CNT_W-1:0]   disp_cnt
);

  logic               buf_valid;
  logic               buf_bcast;
  logic [DATA_W-1:0]  buf_data;
  logic [N_CHILD-1:0] acc_mask;
  logic [N_CHILD-1:0] rr_sel;
  logic [N_CHILD-1:0] hs;
  logic               item_done;
  logic               load;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_CHILD - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // out_valid is built from registered state only, so it never depends on out_ready.
  always_comb begin
    rr_sel = '0;
    for (int i = 0; i < N_CHILD; i++) rr_sel[i] = (rr_ptr == PTR_W'(i));
    if (buf_bcast) out_valid = {N_CHILD{buf_valid}} & ~acc_mask;
    else           out_valid = {N_CHILD{buf_valid}} & rr_sel;
    hs = out_valid & out_ready;
    if (buf_bcast) item_done = buf_valid & (&(acc_mask | hs));
    else           item_done = |hs;
    in_ready = !rst & (!buf_valid | item_done);
    load     = in_valid & in_ready;
    out_data = buf_data;
  end

  // Buffer stage: a completing item and a new load may share the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_bcast <= 1'b0;
      buf_data  <= '0;
      acc_mask  <= '0;
      rr_ptr    <= '0;
      disp_cnt  <= '0;
    end else begin
      if (load) begin
        buf_valid <= 1'b1;
        buf_data  <= in_data;
        buf_bcast <= in_bcast;
        acc_mask  <= '0;
      end else if (item_done) begin
        buf_valid <= 1'b0;
        acc_mask  <= '0;
      end else if (buf_valid && buf_bcast) begin
        acc_mask  <= acc_mask | hs;
      end
      if (item_done && !buf_bcast) rr_ptr <= next_ptr(rr_ptr);
      if (item_done) disp_cnt <= disp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanout_dispatcher.sv
// Directed bench for fanout_dispatcher (N_CHILD=10, CNT_W=4 so the counter wraps).
module tb_fanout_dispatcher;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_bcast;
  logic [9:0]  out_valid;
  logic [9:0]  out_ready;
  logic [31:0] out_data;
  logic [3:0]  rr_ptr;
  logic [3:0]  disp_cnt;

  int checks = 0;
  int errors = 0;

  logic [9:0] seen;
  logic [9:0] dup;
  logic [9:0] exp_ov [6];

  fanout_dispatcher #(.DATA_W(32), .N_CHILD(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bcast(in_bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .rr_ptr(rr_ptr),
    .disp_cnt(disp_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic track_hs;
    dup  = dup | (seen & out_valid & out_ready);
    seen = seen | (out_valid & out_ready);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bcast = 1'b0; out_ready = '0;
    tick; tick;
    settle;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rr_ptr", rr_ptr, 0);
    chk("rst_disp_cnt", disp_cnt, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    settle;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Ten round-robin items, every child ready: one item per cycle.
    out_ready = 10'h3FF;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_data = 32'(j); in_bcast = 1'b0;
      settle;
      chk("rr_in_ready", in_ready, 1);
      if (j > 0) begin
        chk("rr_out_valid", out_valid, 64'(10'h001 << (j - 1)));
        chk("rr_out_data", out_data, 64'(j - 1));
      end
      tick;
    end
    in_valid = 1'b0;
    settle;
    chk("rr_last_valid", out_valid, 10'h200);
    chk("rr_last_data", out_data, 9);
    tick;
    chk("rr_done_valid", out_valid, 0);
    chk("rr_wrap_ptr", rr_ptr, 0);
    chk("rr_cnt10", disp_cnt, 10);

    // Child 3 stalls while item 3 is buffered.
    out_ready = 10'h3F7;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_data = 32'(j);
      tick;
    end
    in_data = 32'd4;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("stall_out_valid", out_valid, 10'h008);
      chk("stall_out_data", out_data, 3);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_rr_ptr", rr_ptr, 3);
      tick;
    end
    chk("stall_cnt", disp_cnt, 13);
    out_ready = 10'h3FF;
    settle;
    chk("unstall_in_ready", in_ready, 1);
    tick;
    chk("unstall_rr_ptr", rr_ptr, 4);
    chk("unstall_out_valid", out_valid, 10'h010);
    chk("unstall_out_data", out_data, 4);
    chk("unstall_cnt", disp_cnt, 14);
    in_valid = 1'b0;
    tick;
    chk("drain_rr_ptr", rr_ptr, 5);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_cnt", disp_cnt, 15);

    // Broadcast with children accepting in staggered groups.
    out_ready = '0;
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 32'hA5A5_0001;
    settle;
    chk("bc_load_ready", in_ready, 1);
    tick;
    in_valid = 1'b0; in_bcast = 1'b0;
    seen = '0; dup = '0;
    chk("bc_all_valid", out_valid, 10'h3FF);
    out_ready = 10'h00F;
    settle; track_hs;
    chk("bc_in_ready_1", in_ready, 0);
    tick;
    chk("bc_valid_1", out_valid, 10'h3F0);
    chk("bc_data_1", out_data, 32'hA5A5_0001);
    out_ready = 10'h0FF;
    settle; track_hs;
    chk("bc_in_ready_2", in_ready, 0);
    tick;
    chk("bc_valid_2", out_valid, 10'h300);
    out_ready = 10'h200;
    settle; track_hs;
    chk("bc_in_ready_3", in_ready, 0);
    tick;
    chk("bc_valid_3", out_valid, 10'h100);
    chk("bc_data_3", out_data, 32'hA5A5_0001);
    out_ready = 10'h100;
    settle; track_hs;
    chk("bc_in_ready_last", in_ready, 1);
    tick;
    chk("bc_done_valid", out_valid, 0);
    chk("bc_seen", seen, 10'h3FF);
    chk("bc_dup", dup, 0);
    chk("bc_rr_ptr", rr_ptr, 5);
    chk("bc_cnt_wrap", disp_cnt, 0);

    // Alternating broadcast / round-robin, all ready, back to back.
    exp_ov[0] = 10'h3FF; exp_ov[1] = 10'h020; exp_ov[2] = 10'h3FF;
    exp_ov[3] = 10'h040; exp_ov[4] = 10'h3FF; exp_ov[5] = 10'h080;
    out_ready = 10'h3FF;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_bcast = (k % 2 == 0); in_data = 32'h100 + 32'(k);
      settle;
      chk("mix_in_ready", in_ready, 1);
      tick;
      settle;
      chk("mix_out_valid", out_valid, exp_ov[k]);
      chk("mix_out_data", out_data, 64'(32'h100 + 32'(k)));
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    tick;
    chk("mix_cnt", disp_cnt, 6);
    chk("mix_rr_ptr", rr_ptr, 8);
    chk("mix_idle", out_valid, 0);

    // Reset in the middle of a broadcast after four children accepted.
    out_ready = '0;
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 32'h0000_BEEF;
    tick;
    in_valid = 1'b0; in_bcast = 1'b0;
    out_ready = 10'h00F;
    tick;
    chk("mid_bc_valid", out_valid, 10'h3F0);
    out_ready = '0;
    rst = 1'b1;
    settle;
    chk("mid_rst_in_ready", in_ready, 0);
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rr_ptr", rr_ptr, 0);
    chk("mid_rst_cnt", disp_cnt, 0);
    chk("mid_rst_data", out_data, 0);
    rst = 1'b0;
    settle;
    chk("mid_rst_ready_after", in_ready, 1);
    chk("mid_rst_valid_after", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h77;
    tick;
    in_valid = 1'b0;
    chk("fresh_valid", out_valid, 10'h001);
    chk("fresh_data", out_data, 32'h77);
    out_ready = 10'h3FF;
    tick;
    chk("fresh_cnt", disp_cnt, 1);
    chk("fresh_rr_ptr", rr_ptr, 1);

    // Counter wrap: 17 items through a 4-bit counter.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int j = 0; j < 17; j++) begin
      in_valid = 1'b1; in_data = 32'(j);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("wrap_cnt", disp_cnt, 1);
    chk("wrap_rr_ptr", rr_ptr, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
